// File: rtl/pcie_pipe_pkg.sv
// Shared definitions for the PIPE receive framer: 8b/10b K codes,
// training-set identifiers, the framer state encoding and the FIFO entry layout.
package pcie_pipe_pkg;

   localparam logic [7:0] K_COM = 8'hBC;
   localparam logic [7:0] K_SKP = 8'h1C;
   localparam logic [7:0] K_STP = 8'hFB;
   localparam logic [7:0] K_SDP = 8'h5C;
   localparam logic [7:0] K_END = 8'hFD;
   localparam logic [7:0] K_EDB = 8'hFE;
   localparam logic [7:0] K_PAD = 8'hF7;
   localparam logic [7:0] K_IDL = 8'h7C;

   localparam logic [7:0] TS1_ID = 8'h4A;
   localparam logic [7:0] TS2_ID = 8'h45;

   localparam int DLLP_BYTES    = 6;
   localparam int TLP_MIN_BYTES = 4;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_OSET,
      ST_TLP,
      ST_DLLP,
      ST_DROP
   } state_e;

   typedef struct packed {
      logic [7:0] data;
      logic       sop;
      logic       eop;
      logic       dllp;
      logic       err;
   } fifo_entry_t;

endpackage

// File: rtl/pcie_pipe_sym_fifo.sv
// Synchronous show-ahead FIFO: the head entry is always visible on headData_o.
// A push while full is accepted only when a pop happens in the same cycle.
module pcie_pipe_sym_fifo #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 12
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             pushEn_i,
   input  logic [WIDTH-1:0] pushData_i,
   input  logic             popEn_i,
   output logic [WIDTH-1:0] headData_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wrPtr_q;
   logic [AW-1:0]    rdPtr_q;
   logic [AW:0]      count_q;
   logic             doPush;
   logic             doPop;

   assign empty_o    = (count_q == '0);
   assign full_o     = (count_q == (AW+1)'(DEPTH));
   assign doPop      = popEn_i && !empty_o;
   assign doPush     = pushEn_i && (!full_o || doPop);
   assign headData_o = mem_q[rdPtr_q];

   // Pointer and occupancy bookkeeping; pointers wrap naturally since DEPTH is a power of two.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         count_q <= '0;
      end else begin
         if (doPush) wrPtr_q <= wrPtr_q + 1'b1;
         if (doPop)  rdPtr_q <= rdPtr_q + 1'b1;
         if (doPush && !doPop)      count_q <= count_q + 1'b1;
         else if (doPop && !doPush) count_q <= count_q - 1'b1;
      end
   end

   // Storage array; contents are don't-care until written, so it carries no reset.
   always_ff @(posedge clk_i) begin
      if (doPush) mem_q[wrPtr_q] <= pushData_i;
   end

endmodule

// File: rtl/pcie_pipe_rx_framer.sv
// PIPE receive framer: splits the x1 symbol stream into TLP/DLLP byte packets,
// flags bad packets, counts SKP/TS1/TS2 ordered sets and buffers bytes in a FIFO.
module pcie_pipe_rx_framer
   import pcie_pipe_pkg::*;
#(
   parameter int FIFO_DEPTH    = 16,
   parameter int MAX_PKT_BYTES = 4096
) (
   input  logic        pclk,
   input  logic        reset,
   input  logic [7:0]  RxData,
   input  logic        RxDataK,
   output logic [7:0]  out_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        out_sop,
   output logic        out_eop,
   output logic        out_dllp,
   output logic        out_err,
   output logic        framing_err,
   output logic        overflow,
   output logic [15:0] skp_cnt,
   output logic [15:0] ts1_cnt,
   output logic [15:0] ts2_cnt
);

   localparam int                CNT_W   = $clog2(MAX_PKT_BYTES + 1);
   localparam logic [CNT_W-1:0]  MAX_CNT = CNT_W'(MAX_PKT_BYTES);
   localparam int                ENTRY_W = $bits(fifo_entry_t);

   state_e           state_q, state_d;
   logic [3:0]       osetIdx_q, osetIdx_d;
   logic             skpMode_q, skpMode_d;
   logic             ts1Ok_q, ts1Ok_d, ts2Ok_q, ts2Ok_d;
   logic             holdValid_q, holdValid_d;
   logic [7:0]       holdData_q, holdData_d;
   logic             holdSop_q, holdSop_d;
   logic             pktDllp_q, pktDllp_d;
   logic [CNT_W-1:0] byteCnt_q, byteCnt_d;
   logic             framingErr_q, framingErr_d;
   logic             overflow_q, overflow_d;
   logic [15:0]      skpCnt_q, skpCnt_d, ts1Cnt_q, ts1Cnt_d, ts2Cnt_q, ts2Cnt_d;

   logic             isCom, isSkp, isStp, isSdp, isEnd, isEdb;
   logic             startIdle, ts1Next, ts2Next, lenBad;
   logic             pushReq, pushOk, popFire, fifoFull, fifoEmpty;
   fifo_entry_t      pushEntry, headEntry;
   logic [ENTRY_W-1:0] fifoHead;

   assign isCom = RxDataK && (RxData == K_COM);
   assign isSkp = RxDataK && (RxData == K_SKP);
   assign isStp = RxDataK && (RxData == K_STP);
   assign isSdp = RxDataK && (RxData == K_SDP);
   assign isEnd = RxDataK && (RxData == K_END);
   assign isEdb = RxDataK && (RxData == K_EDB);

   assign popFire = !fifoEmpty && out_ready;
   assign lenBad  = pktDllp_q ? (byteCnt_q != CNT_W'(DLLP_BYTES))
                              : (byteCnt_q < CNT_W'(TLP_MIN_BYTES));

   // Next-state decode: one symbol per cycle, at most one FIFO push per cycle.
   always_comb begin
      state_d      = state_q;
      osetIdx_d    = osetIdx_q;
      skpMode_d    = skpMode_q;
      ts1Ok_d      = ts1Ok_q;
      ts2Ok_d      = ts2Ok_q;
      holdValid_d  = holdValid_q;
      holdData_d   = holdData_q;
      holdSop_d    = holdSop_q;
      pktDllp_d    = pktDllp_q;
      byteCnt_d    = byteCnt_q;
      framingErr_d = 1'b0;
      overflow_d   = overflow_q;
      skpCnt_d     = skpCnt_q;
      ts1Cnt_d     = ts1Cnt_q;
      ts2Cnt_d     = ts2Cnt_q;
      startIdle    = 1'b0;
      ts1Next      = ts1Ok_q;
      ts2Next      = ts2Ok_q;
      pushReq      = 1'b0;
      pushEntry    = '0;
      pushOk       = 1'b0;

      case (state_q)
         ST_IDLE: startIdle = 1'b1;
         ST_OSET: begin
            if (skpMode_q) begin
               if (!isSkp) begin
                  skpCnt_d  = skpCnt_q + 16'd1;
                  skpMode_d = 1'b0;
                  state_d   = ST_IDLE;
                  startIdle = 1'b1;
               end
            end else if (isCom) begin
               osetIdx_d = 4'd1;
               ts1Ok_d   = 1'b1;
               ts2Ok_d   = 1'b1;
            end else if (osetIdx_q == 4'd1 && isSkp) begin
               skpMode_d = 1'b1;
            end else begin
               if (osetIdx_q >= 4'd6) begin
                  ts1Next = ts1Ok_q && !RxDataK && (RxData == TS1_ID);
                  ts2Next = ts2Ok_q && !RxDataK && (RxData == TS2_ID);
               end
               if (osetIdx_q == 4'd15) begin
                  if (ts1Next)      ts1Cnt_d = ts1Cnt_q + 16'd1;
                  else if (ts2Next) ts2Cnt_d = ts2Cnt_q + 16'd1;
                  state_d = ST_IDLE;
               end else begin
                  osetIdx_d = osetIdx_q + 4'd1;
                  ts1Ok_d   = ts1Next;
                  ts2Ok_d   = ts2Next;
               end
            end
         end
         ST_TLP, ST_DLLP: begin
            if (!RxDataK) begin
               if (holdValid_q) begin
                  pushReq   = 1'b1;
                  pushEntry = '{data: holdData_q, sop: holdSop_q, eop: 1'b0,
                                dllp: pktDllp_q, err: 1'b0};
               end
               holdData_d  = RxData;
               holdValid_d = 1'b1;
               holdSop_d   = !holdValid_q;
               if (byteCnt_q == MAX_CNT) state_d = ST_DROP;
               else                      byteCnt_d = byteCnt_q + 1'b1;
            end else begin
               holdValid_d = 1'b0;
               state_d     = ST_IDLE;
               if (holdValid_q) begin
                  pushReq   = 1'b1;
                  pushEntry = '{data: holdData_q, sop: holdSop_q, eop: 1'b1,
                                dllp: pktDllp_q, err: (isEnd ? lenBad : 1'b1)};
               end else if (isEnd || isEdb) begin
                  framingErr_d = 1'b1;
               end
               if (!isEnd && !isEdb) startIdle = 1'b1;
            end
         end
         ST_DROP: begin
            if (holdValid_q) begin
               pushReq     = 1'b1;
               pushEntry   = '{data: holdData_q, sop: holdSop_q, eop: 1'b1,
                               dllp: pktDllp_q, err: 1'b1};
               holdValid_d = 1'b0;
            end
            if (isEnd || isEdb) state_d = ST_IDLE;
            else                startIdle = 1'b1;
         end
         default: state_d = ST_IDLE;
      endcase

      if (startIdle) begin
         if (isStp || isSdp) begin
            state_d     = isStp ? ST_TLP : ST_DLLP;
            pktDllp_d   = isSdp;
            byteCnt_d   = '0;
            holdValid_d = 1'b0;
         end else if (isCom) begin
            state_d   = ST_OSET;
            osetIdx_d = 4'd1;
            skpMode_d = 1'b0;
            ts1Ok_d   = 1'b1;
            ts2Ok_d   = 1'b1;
         end else if (isEnd || isEdb) begin
            framingErr_d = 1'b1;
         end
      end

      pushOk = pushReq && (!fifoFull || popFire);
      if (pushReq && !pushOk) begin
         overflow_d  = 1'b1;
         state_d     = ST_DROP;
         holdValid_d = 1'b0;
      end
   end

   // Framer state and status registers; reset discards any partial packet.
   always_ff @(posedge pclk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         osetIdx_q    <= '0;
         skpMode_q    <= 1'b0;
         ts1Ok_q      <= 1'b0;
         ts2Ok_q      <= 1'b0;
         holdValid_q  <= 1'b0;
         holdData_q   <= '0;
         holdSop_q    <= 1'b0;
         pktDllp_q    <= 1'b0;
         byteCnt_q    <= '0;
         framingErr_q <= 1'b0;
         overflow_q   <= 1'b0;
         skpCnt_q     <= '0;
         ts1Cnt_q     <= '0;
         ts2Cnt_q     <= '0;
      end else begin
         state_q      <= state_d;
         osetIdx_q    <= osetIdx_d;
         skpMode_q    <= skpMode_d;
         ts1Ok_q      <= ts1Ok_d;
         ts2Ok_q      <= ts2Ok_d;
         holdValid_q  <= holdValid_d;
         holdData_q   <= holdData_d;
         holdSop_q    <= holdSop_d;
         pktDllp_q    <= pktDllp_d;
         byteCnt_q    <= byteCnt_d;
         framingErr_q <= framingErr_d;
         overflow_q   <= overflow_d;
         skpCnt_q     <= skpCnt_d;
         ts1Cnt_q     <= ts1Cnt_d;
         ts2Cnt_q     <= ts2Cnt_d;
      end
   end

   pcie_pipe_sym_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (ENTRY_W)
   ) uFifo (
      .clk_i      (pclk),
      .rst_i      (reset),
      .pushEn_i   (pushOk),
      .pushData_i (pushEntry),
      .popEn_i    (popFire),
      .headData_o (fifoHead),
      .full_o     (fifoFull),
      .empty_o    (fifoEmpty)
   );

   // Stale storage behind an empty FIFO is masked so idle outputs read as zero.
   assign headEntry   = fifoEmpty ? '0 : fifoHead;
   assign out_valid   = !fifoEmpty;
   assign out_data    = headEntry.data;
   assign out_sop     = headEntry.sop;
   assign out_eop     = headEntry.eop;
   assign out_dllp    = headEntry.dllp;
   assign out_err     = headEntry.err;
   assign framing_err = framingErr_q;
   assign overflow    = overflow_q;
   assign skp_cnt     = skpCnt_q;
   assign ts1_cnt     = ts1Cnt_q;
   assign ts2_cnt     = ts2Cnt_q;

endmodule

// File: tb/tb_pcie_pipe_rx_framer.sv
// Directed bench for the PIPE receive framer: packets, ordered sets,
// backpressure overflow and mid-packet reset.
module tb_pcie_pipe_rx_framer;

   logic        pclk = 1'b0;
   logic        reset;
   logic [7:0]  RxData;
   logic        RxDataK;
   logic [7:0]  out_data;
   logic        out_valid;
   logic        out_ready;
   logic        out_sop, out_eop, out_dllp, out_err;
   logic        framing_err, overflow;
   logic [15:0] skp_cnt, ts1_cnt, ts2_cnt;

   int checks   = 0;
   int failures = 0;

   logic [11:0] beats [$];

   pcie_pipe_rx_framer #(.FIFO_DEPTH(16), .MAX_PKT_BYTES(4096)) dut (
      .pclk        (pclk),
      .reset       (reset),
      .RxData      (RxData),
      .RxDataK     (RxDataK),
      .out_data    (out_data),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_sop     (out_sop),
      .out_eop     (out_eop),
      .out_dllp    (out_dllp),
      .out_err     (out_err),
      .framing_err (framing_err),
      .overflow    (overflow),
      .skp_cnt     (skp_cnt),
      .ts1_cnt     (ts1_cnt),
      .ts2_cnt     (ts2_cnt)
   );

   // Symbol clock.
   always #5 pclk = ~pclk;

   // Record every accepted beat mid-cycle, before the edge that pops it.
   always @(negedge pclk) begin
      if (!reset && out_valid && out_ready)
         beats.push_back({out_data, out_sop, out_eop, out_dllp, out_err});
   end

   // Drive one symbol, let the edge sample it, then settle just after the edge.
   task automatic applyStimulus(input logic k, input logic [7:0] d);
      RxDataK = k;
      RxData  = d;
      @(posedge pclk);
      #1;
   endtask

   task automatic idleCycles(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 8'h00);
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         failures++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   function automatic logic [11:0] beatAt(input int idx);
      if (idx < beats.size()) return beats[idx];
      return {12{1'bx}};
   endfunction

   function automatic logic [11:0] mkBeat(input logic [7:0] d, input logic sop,
                                          input logic eop, input logic dllp, input logic err);
      return {d, sop, eop, dllp, err};
   endfunction

   initial begin
      reset     = 1'b1;
      RxData    = 8'h00;
      RxDataK   = 1'b0;
      out_ready = 1'b1;
      repeat (2) @(posedge pclk);
      #1;
      $display("[TB] reset state");
      checkOutput("rst_valid", out_valid, 0);
      checkOutput("rst_data", out_data, 0);
      checkOutput("rst_ovf", overflow, 0);
      checkOutput("rst_ferr", framing_err, 0);
      checkOutput("rst_skp", skp_cnt, 0);
      reset = 1'b0;
      idleCycles(2);

      $display("[TB] 8-byte TLP");
      beats.delete();
      applyStimulus(1'b1, 8'hFB);
      applyStimulus(1'b0, 8'h00);
      checkOutput("lat_valid_lo", out_valid, 0);
      applyStimulus(1'b0, 8'h01);
      checkOutput("lat_valid_hi", out_valid, 1);
      checkOutput("lat_head_data", out_data, 8'h00);
      checkOutput("lat_head_sop", out_sop, 1);
      for (int i = 2; i < 8; i++) applyStimulus(1'b0, 8'(i));
      applyStimulus(1'b1, 8'hFD);
      idleCycles(3);
      checkOutput("tlp8_count", beats.size(), 8);
      checkOutput("tlp8_b0", beatAt(0), mkBeat(8'h00, 1, 0, 0, 0));
      checkOutput("tlp8_b3", beatAt(3), mkBeat(8'h03, 0, 0, 0, 0));
      checkOutput("tlp8_b7", beatAt(7), mkBeat(8'h07, 0, 1, 0, 0));

      $display("[TB] DLLPs of 6 and 5 bytes");
      beats.delete();
      applyStimulus(1'b1, 8'h5C);
      for (int i = 0; i < 6; i++) applyStimulus(1'b0, 8'(8'h10 + i));
      applyStimulus(1'b1, 8'hFD);
      applyStimulus(1'b1, 8'h5C);
      for (int i = 0; i < 5; i++) applyStimulus(1'b0, 8'(8'h20 + i));
      applyStimulus(1'b1, 8'hFD);
      idleCycles(3);
      checkOutput("dllp_count", beats.size(), 11);
      checkOutput("dllp6_b0", beatAt(0), mkBeat(8'h10, 1, 0, 1, 0));
      checkOutput("dllp6_eop", beatAt(5), mkBeat(8'h15, 0, 1, 1, 0));
      checkOutput("dllp5_b0", beatAt(6), mkBeat(8'h20, 1, 0, 1, 0));
      checkOutput("dllp5_eop", beatAt(10), mkBeat(8'h24, 0, 1, 1, 1));

      $display("[TB] EDB and zero-length TLP");
      beats.delete();
      applyStimulus(1'b1, 8'hFB);
      for (int i = 0; i < 4; i++) applyStimulus(1'b0, 8'(8'h30 + i));
      applyStimulus(1'b1, 8'hFE);
      checkOutput("edb_no_ferr", framing_err, 0);
      idleCycles(3);
      checkOutput("edb_count", beats.size(), 4);
      checkOutput("edb_eop", beatAt(3), mkBeat(8'h33, 0, 1, 0, 1));
      beats.delete();
      applyStimulus(1'b1, 8'hFB);
      applyStimulus(1'b1, 8'hFD);
      checkOutput("zlen_ferr_pulse", framing_err, 1);
      applyStimulus(1'b0, 8'h00);
      checkOutput("zlen_ferr_clear", framing_err, 0);
      idleCycles(2);
      checkOutput("zlen_count", beats.size(), 0);

      $display("[TB] ordered sets");
      beats.delete();
      applyStimulus(1'b1, 8'hBC);
      repeat (3) applyStimulus(1'b1, 8'h1C);
      applyStimulus(1'b1, 8'hBC);
      for (int i = 1; i <= 15; i++) applyStimulus(1'b0, (i >= 6) ? 8'h4A : 8'h00);
      checkOutput("ts1_after", ts1_cnt, 1);
      applyStimulus(1'b1, 8'hBC);
      for (int i = 1; i <= 15; i++) applyStimulus(1'b0, (i >= 6) ? 8'h45 : 8'h00);
      idleCycles(2);
      checkOutput("oset_skp", skp_cnt, 1);
      checkOutput("oset_ts1", ts1_cnt, 1);
      checkOutput("oset_ts2", ts2_cnt, 1);
      checkOutput("oset_count", beats.size(), 0);

      $display("[TB] backpressure overflow");
      beats.delete();
      out_ready = 1'b0;
      applyStimulus(1'b1, 8'hFB);
      for (int i = 0; i < 40; i++) applyStimulus(1'b0, 8'(i));
      applyStimulus(1'b1, 8'hFD);
      checkOutput("ovf_flag", overflow, 1);
      checkOutput("ovf_head_valid", out_valid, 1);
      checkOutput("ovf_head_data", out_data, 8'h00);
      out_ready = 1'b1;
      idleCycles(18);
      checkOutput("ovf_count", beats.size(), 16);
      checkOutput("ovf_b0", beatAt(0), mkBeat(8'h00, 1, 0, 0, 0));
      checkOutput("ovf_b15", beatAt(15), mkBeat(8'h0F, 0, 0, 0, 0));
      checkOutput("ovf_sticky", overflow, 1);
      beats.delete();
      applyStimulus(1'b1, 8'hFB);
      for (int i = 0; i < 4; i++) applyStimulus(1'b0, 8'(8'hA0 + i));
      applyStimulus(1'b1, 8'hFD);
      idleCycles(3);
      checkOutput("post_ovf_count", beats.size(), 4);
      checkOutput("post_ovf_b0", beatAt(0), mkBeat(8'hA0, 1, 0, 0, 0));
      checkOutput("post_ovf_b3", beatAt(3), mkBeat(8'hA3, 0, 1, 0, 0));

      $display("[TB] reset mid-packet");
      beats.delete();
      out_ready = 1'b0;
      applyStimulus(1'b1, 8'hFB);
      applyStimulus(1'b0, 8'hB0);
      applyStimulus(1'b0, 8'hB1);
      applyStimulus(1'b0, 8'hB2);
      checkOutput("pre_rst_valid", out_valid, 1);
      reset     = 1'b1;
      out_ready = 1'b1;
      #1;
      checkOutput("mid_rst_valid", out_valid, 0);
      checkOutput("mid_rst_data", out_data, 0);
      checkOutput("mid_rst_ovf", overflow, 0);
      checkOutput("mid_rst_ts1", ts1_cnt, 0);
      applyStimulus(1'b0, 8'hB3);
      reset = 1'b0;
      applyStimulus(1'b0, 8'hB4);
      applyStimulus(1'b0, 8'hB5);
      idleCycles(3);
      checkOutput("post_rst_count", beats.size(), 0);
      applyStimulus(1'b1, 8'hFB);
      for (int i = 0; i < 5; i++) applyStimulus(1'b0, 8'(8'hC0 + i));
      applyStimulus(1'b1, 8'hFD);
      idleCycles(3);
      checkOutput("clean_count", beats.size(), 5);
      checkOutput("clean_b0", beatAt(0), mkBeat(8'hC0, 1, 0, 0, 0));
      checkOutput("clean_b4", beatAt(4), mkBeat(8'hC4, 0, 1, 0, 0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
